// File: rtl/rr_req_frontend.sv
// rr_req_frontend: requester-side front end for an external round-robin arbiter.
// Each channel has a small FIFO of burst lengths. The block shows which queues are
// non-empty as a request vector and enables arbitration only while idle. It takes the
// arbiter's registered one-hot grant and then streams the winner's burst downstream
// using a valid/ready handshake.
//
// Ports:
//   i_clk    clock
//   i_rstn   synchronous active-low reset
//   i_push   per-channel push strobe
//   i_len    packed per-channel burst length (len+1 beats), sampled with i_push
//   o_full   per-channel queue full (push while full is dropped)
//   o_req    request vector to the arbiter (queue non-empty)
//   o_en     arbitration enable to the arbiter
//   i_gnt    registered grant vector from the arbiter
//   o_valid  downstream beat valid
//   i_ready  downstream ready
//   o_sel    channel index owning the current burst
//   o_last   final beat of the burst
//   o_err    sticky error (dropped push, missing/multi-hot grant, grant to empty queue)

module rr_req_frontend #(
  parameter int unsigned N = 10,
  parameter int unsigned L = 3,
  parameter int unsigned D = 4,
  localparam int unsigned M = (N > 1) ? $clog2(N) : 1
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [N-1:0]   i_push,
  input  logic [N*L-1:0] i_len,
  output logic [N-1:0]   o_full,
  output logic [N-1:0]   o_req,
  output logic           o_en,
  input  logic [N-1:0]   i_gnt,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [M-1:0]   o_sel,
  output logic           o_last,
  output logic           o_err
);

  localparam int unsigned P = $clog2(D);  // queue pointer width (D is a power of 2, >= 2)
  localparam int unsigned C = P + 1;      // occupancy width, holds 0..D

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  // Per-channel queues
  logic [L-1:0] mem_q    [N][D];
  logic [P-1:0] wr_ptr_q [N];
  logic [P-1:0] rd_ptr_q [N];
  logic [C-1:0] fill_q   [N];

  logic [N-1:0] full;
  logic [N-1:0] empty;
  logic [N-1:0] push_ok;
  logic [N-1:0] drop;
  logic [N-1:0] pop;

  // Control state
  state_e       state_q, state_d;
  logic [M-1:0] sel_q, sel_d;
  logic [L-1:0] beat_q, beat_d;
  logic         err_q, err_d;

  // Grant decode
  logic [M-1:0] gnt_idx;
  logic         gnt_multi;
  logic [L-1:0] head_len;

  always_comb begin
    full    = '0;
    empty   = '0;
    push_ok = '0;
    drop    = '0;
    for (int i = 0; i < N; i++) begin
      full[i]    = (fill_q[i] == C'(D));
      empty[i]   = (fill_q[i] == '0);
      // Fullness is the registered value, so a push to a full queue is dropped even
      // when that queue pops in the same cycle.
      push_ok[i] = i_push[i] & ~full[i];
      drop[i]    = i_push[i] & full[i];
    end
  end

  assign o_full = full;
  assign o_req  = ~empty;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + P'(1);
        if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + P'(1);
        if (push_ok[i] && !pop[i]) begin
          fill_q[i] <= fill_q[i] + C'(1);
        end else if (pop[i] && !push_ok[i]) begin
          fill_q[i] <= fill_q[i] - C'(1);
        end
      end
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= i_len[i*L +: L];
    end
  end

  // A multi-hot grant falls back to its lowest set index.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_gnt[i]) gnt_idx = M'(i);
    end
  end

  assign gnt_multi = ((i_gnt & (i_gnt - N'(1))) != '0);
  assign head_len  = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    err_d   = err_q | (|drop);
    pop     = '0;
    unique case (state_q)
      StIdle: begin
        // The arbiter registers its grant on the same edge that takes us to StWait.
        if (|o_req) state_d = StWait;
      end
      StWait: begin
        state_d = StIdle;
        if (i_gnt == '0 || empty[gnt_idx]) begin
          err_d = 1'b1;
        end else begin
          if (gnt_multi) err_d = 1'b1;
          sel_d        = gnt_idx;
          beat_d       = head_len;
          pop[gnt_idx] = 1'b1;
          state_d      = StBurst;
        end
      end
      StBurst: begin
        // beat_q counts beats remaining after the current one.
        if (i_ready) begin
          if (beat_q == '0) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q - L'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_en    = (state_q == StIdle) && (|o_req);
    o_valid = (state_q == StBurst);
    o_last  = (state_q == StBurst) && (beat_q == '0);
  end

  assign o_sel = sel_q;
  assign o_err = err_q;

endmodule

// File: tb/tb_rr_req_frontend.sv
// Testbench for rr_req_frontend (N=4, L=3, D=4).
// It keeps a queue-based reference model that is updated on each rising edge, plus a
// small round-robin arbiter. Every falling edge the outputs are compared against the
// model, and directed scenarios add hand-computed literal checks.

module tb_rr_req_frontend;

  localparam int N = 4;
  localparam int L = 3;
  localparam int D = 4;
  localparam int M = 2;

  logic           clk;
  logic           i_rstn;
  logic [N-1:0]   i_push;
  logic [N*L-1:0] i_len;
  logic [N-1:0]   o_full;
  logic [N-1:0]   o_req;
  logic           o_en;
  logic [N-1:0]   i_gnt;
  logic           o_valid;
  logic           i_ready;
  logic [M-1:0]   o_sel;
  logic           o_last;
  logic           o_err;

  rr_req_frontend #(.N(N), .L(L), .D(D)) dut (
    .i_clk   (clk),
    .i_rstn  (i_rstn),
    .i_push  (i_push),
    .i_len   (i_len),
    .o_full  (o_full),
    .o_req   (o_req),
    .o_en    (o_en),
    .i_gnt   (i_gnt),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sel   (o_sel),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant source: either a manual vector or a simple round-robin arbiter.
  logic           arb_auto;
  logic [N-1:0]   gnt_man;
  logic [N-1:0]   arb_gnt;
  int             arb_ptr;
  assign i_gnt = arb_auto ? arb_gnt : gnt_man;

  initial begin
    int pick;
    forever begin
      @(posedge clk);
      if (!i_rstn) begin
        arb_gnt <= '0;
        arb_ptr <= 0;
      end else if (o_en) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && o_req[(arb_ptr + k) % N]) pick = (arb_ptr + k) % N;
        end
        if (pick >= 0) begin
          arb_gnt <= N'(1) << pick;
          arb_ptr <= (pick + 1) % N;
        end else begin
          arb_gnt <= '0;
        end
      end else begin
        arb_gnt <= '0;
      end
    end
  end

  // Reference model: queues of burst lengths plus phase / remaining-beat bookkeeping.
  int   mq [N][$];
  int   m_phase;  // 0 idle, 1 waiting for grant, 2 bursting
  int   m_sel;
  int   m_rem;    // beats still to transfer, including the current one
  bit   m_err;

  initial begin
    int pre_sz [N];
    bit any;
    int lo;
    m_phase = 0; m_sel = 0; m_rem = 0; m_err = 0;
    forever begin
      @(posedge clk);
      if (!i_rstn) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        m_phase = 0; m_sel = 0; m_rem = 0; m_err = 0;
      end else begin
        any = 0;
        for (int i = 0; i < N; i++) begin
          pre_sz[i] = mq[i].size();
          if (pre_sz[i] != 0) any = 1;
        end
        case (m_phase)
          0: if (any) m_phase = 1;
          1: begin
            m_phase = 0;
            if (i_gnt == '0) begin
              m_err = 1;
            end else begin
              lo = 0;
              while (!i_gnt[lo]) lo++;
              if ($countones(i_gnt) > 1) m_err = 1;
              if (pre_sz[lo] == 0) begin
                m_err = 1;
              end else begin
                m_sel   = lo;
                m_rem   = mq[lo].pop_front() + 1;
                m_phase = 2;
              end
            end
          end
          default: begin
            if (i_ready) begin
              m_rem--;
              if (m_rem == 0) m_phase = 0;
            end
          end
        endcase
        for (int i = 0; i < N; i++) begin
          if (i_push[i]) begin
            if (pre_sz[i] == D) m_err = 1;
            else mq[i].push_back(int'(i_len[i*L +: L]));
          end
        end
      end
    end
  end

  // Transfer monitor
  int beats, lasts, en_cnt, cyc, last_beat;
  int served [$];
  int last_cyc [$];

  initial begin
    beats = 0; lasts = 0; en_cnt = 0; cyc = 0; last_beat = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (i_rstn && o_en) en_cnt++;
      if (i_rstn && o_valid && i_ready) begin
        beats++;
        if (o_last) begin
          lasts++;
          last_beat = beats;
          served.push_back(int'(o_sel));
          last_cyc.push_back(cyc);
        end
      end
    end
  end

  // Checking
  int total, bad;
  bit chk_on;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic [N-1:0] er, ef;
    for (int i = 0; i < N; i++) begin
      er[i] = (mq[i].size() != 0);
      ef[i] = (mq[i].size() == D);
    end
    chk("cyc_req",   32'(o_req),   32'(er));
    chk("cyc_full",  32'(o_full),  32'(ef));
    chk("cyc_en",    32'(o_en),    32'(m_phase == 0 && er != '0));
    chk("cyc_valid", 32'(o_valid), 32'(m_phase == 2));
    chk("cyc_last",  32'(o_last),  32'(m_phase == 2 && m_rem == 1));
    chk("cyc_sel",   32'(o_sel),   32'(m_sel));
    chk("cyc_err",   32'(o_err),   32'(m_err));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_on) cmp_cycle();
  endtask

  task automatic push1(input int ch, input int len);
    i_push[ch] = 1'b1;
    i_len[ch*L +: L] = L'(len);
    tick();
    i_push = '0;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    tick();
    tick();
    i_rstn = 1'b1;
  endtask

  task automatic wait_lasts(input string name, input int target, input int limit);
    int n = 0;
    while (lasts < target && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(lasts >= target), 32'd1);
  endtask

  int b0, l0, e0, s0, n;

  initial begin
    i_rstn = 1'b0; i_push = '0; i_len = '0; i_ready = 1'b0;
    gnt_man = '0; arb_auto = 1'b0; chk_on = 1'b0; total = 0; bad = 0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_req",   32'(o_req),   32'd0);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_sel",   32'(o_sel),   32'd0);
    i_rstn = 1'b1;

    // Single burst: ch2 len=3 -> 4 beats
    i_ready = 1'b1; b0 = beats; l0 = lasts; e0 = en_cnt; s0 = served.size();
    push1(2, 3);
    chk("t1_req", 32'(o_req), 32'b0100);
    chk("t1_en",  32'(o_en),  32'd1);
    gnt_man = 4'b0100;
    wait_lasts("t1_done", l0 + 1, 30);
    gnt_man = '0;
    tick(); tick();
    chk("t1_beats",   32'(beats - b0),     32'd4);
    chk("t1_lastpos", 32'(last_beat - b0), 32'd4);
    chk("t1_en_once", 32'(en_cnt - e0),    32'd1);
    chk("t1_sel",     32'(served[s0]),     32'd2);
    chk("t1_req_end", 32'(o_req),          32'd0);

    // Backpressure: ch0 len=1, ready toggling
    do_reset();
    i_ready = 1'b0; b0 = beats; l0 = lasts; s0 = served.size();
    push1(0, 1);
    gnt_man = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      tick();
      i_ready = ~i_ready;
    end
    gnt_man = '0; i_ready = 1'b1;
    tick();
    chk("t2_beats",   32'(beats - b0),     32'd2);
    chk("t2_lasts",   32'(lasts - l0),     32'd1);
    chk("t2_lastpos", 32'(last_beat - b0), 32'd2);
    chk("t2_sel",     32'(served[s0]),     32'd0);

    // Full queue: 5 pushes on ch1, no grant, then drain with the arbiter
    do_reset();
    chk("t3_err_clr", 32'(o_err), 32'd0);
    for (int k = 0; k < 4; k++) push1(1, 0);
    chk("t3_full", 32'(o_full), 32'b0010);
    push1(1, 0);
    chk("t3_err",   32'(o_err),  32'd1);
    chk("t3_full2", 32'(o_full), 32'b0010);
    l0 = lasts;
    arb_auto = 1'b1;
    wait_lasts("t3_drain", l0 + 4, 60);
    repeat (10) tick();
    chk("t3_bursts", 32'(lasts - l0), 32'd4);
    chk("t3_req",    32'(o_req),      32'd0);

    // Multi-channel with round-robin arbiter: served 0,1,3 spaced 3 cycles
    do_reset();
    l0 = lasts; s0 = served.size();
    i_push = 4'b1011; i_len = '0;
    tick();
    i_push = '0;
    wait_lasts("t4_done", l0 + 3, 40);
    chk("t4_ord0", 32'(served[s0]),     32'd0);
    chk("t4_ord1", 32'(served[s0 + 1]), 32'd1);
    chk("t4_ord2", 32'(served[s0 + 2]), 32'd3);
    chk("t4_gap1", 32'(last_cyc[s0 + 1] - last_cyc[s0]),     32'd3);
    chk("t4_gap2", 32'(last_cyc[s0 + 2] - last_cyc[s0 + 1]), 32'd3);

    // Bad grants: zero grant, then multi-hot 1010 serves ch1
    do_reset();
    arb_auto = 1'b0; gnt_man = '0;
    l0 = lasts; s0 = served.size();
    i_push = 4'b1010; i_len = '0;
    tick();
    i_push = '0;
    repeat (3) tick();
    chk("t5_err",  32'(o_err), 32'd1);
    chk("t5_req",  32'(o_req), 32'b1010);
    gnt_man = 4'b1010;
    wait_lasts("t5_done", l0 + 1, 20);
    gnt_man = '0;
    tick();
    chk("t5_sel",  32'(served[s0]), 32'd1);
    chk("t5_req2", 32'(o_req),      32'b1000);

    // Mid-burst reset: ch2 len=7, reset after 3 beats
    do_reset();
    arb_auto = 1'b1; i_ready = 1'b1; b0 = beats;
    push1(2, 7);
    n = 0;
    while (beats - b0 < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_reach3", 32'(beats - b0 >= 3), 32'd1);
    i_rstn = 1'b0;
    tick();
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_req",   32'(o_req),   32'd0);
    i_rstn = 1'b1;
    repeat (20) tick();
    chk("t6_beats",  32'(beats - b0), 32'd3);
    chk("t6_valid2", 32'(o_valid),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
